// File: rtl/cache_pkg.sv
// Shared widths and line types for the set-associative cache array and its LRU.
// Optional byte-lane writes are enabled with the CACHE_BYTE_WRITE_EN macro.
package cache_pkg;

   localparam int DEF_WAYS      = 2;
   localparam int DEF_SETS      = 64;
   localparam int DEF_WORDS     = 4;
   localparam int DEF_WORD_SIZE = 32;

   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   localparam int INDEX_W   = $clog2(DEF_SETS);
   localparam int OFFSET_W  = $clog2(DEF_WORDS);
   localparam int AGE_W     = way_w(DEF_WAYS);
   localparam int TAG_W_DEF = 32 - INDEX_W - OFFSET_W;

   typedef logic [DEF_WORDS*DEF_WORD_SIZE-1:0] block_t;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_W_DEF-1:0] tag;
      block_t               block;
   } line_t;

endpackage

// File: rtl/cache_lru.sv
// Per-set age-based LRU: tracks recency per way and names the replacement victim.
module cache_lru
   import cache_pkg::*;
#(
   parameter  int WAYS  = 2,
   parameter  int SETS  = 64,
   localparam int WAY_W = way_w(WAYS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(SETS)-1:0] index,
   input  logic                    touch,
   input  logic [WAY_W-1:0]        touch_way,
   input  logic [WAYS-1:0]         valid,
   output logic [WAY_W-1:0]        victim
);

   if (WAYS == 1) begin : g_direct
      assign victim = '0;
   end else begin : g_lru
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] age_d [SETS][WAYS];
      logic [WAY_W-1:0] old_age;

      // Touched way becomes age 0; only younger ways age, so ages stay a permutation.
      always_comb begin
         age_d   = age_q;
         old_age = age_q[index][touch_way];
         if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == touch_way)
                  age_d[index][w] = '0;
               else if (age_q[index][w] < old_age)
                  age_d[index][w] = age_q[index][w] + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++)
                  age_q[s][w] <= WAY_W'(w);
         end else begin
            age_q <= age_d;
         end
      end

      // Lowest invalid way wins; otherwise the oldest way.
      always_comb begin
         victim = '0;
         for (int w = 0; w < WAYS; w++)
            if (age_q[index][w] == WAY_W'(WAYS - 1))
               victim = WAY_W'(w);
         for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w])
               victim = WAY_W'(w);
      end
   end

endmodule

// File: rtl/set_assoc_cache_memory.sv
// N-way set-associative cache array: hit resolution, LRU victim, refill and word writes.
// Define CACHE_BYTE_WRITE_EN to add the byte_en port and byte-lane write hits.
module set_assoc_cache_memory
   import cache_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int SETS      = 64,
   parameter int WORDS     = 4,
   parameter int WORD_SIZE = 32,
   parameter int TAG_W     = 32 - $clog2(SETS) - $clog2(WORDS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [TAG_W-1:0]           tag,
   input  logic [$clog2(SETS)-1:0]    index,
   input  logic [$clog2(WORDS)-1:0]   blk_offset,
   input  logic                       req_type,
   input  logic                       read_en_cache,
   input  logic                       write_en_cache,
   input  logic                       ready_mem,
   input  logic [WORDS*WORD_SIZE-1:0] data_in_mem,
   input  logic [WORD_SIZE-1:0]       data_in,
`ifdef CACHE_BYTE_WRITE_EN
   input  logic [WORD_SIZE/8-1:0]     byte_en,
`endif
   output logic                       hit,
   output logic                       dirty_bit,
   output logic [WORD_SIZE-1:0]       data_out,
   output logic [WORDS*WORD_SIZE-1:0] dirty_block_out,
   output logic [TAG_W-1:0]           evict_tag,
   output logic                       done_cache
);

   localparam int WAY_W = way_w(WAYS);
   localparam int BLK_W = WORDS * WORD_SIZE;

   logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
   logic [BLK_W-1:0] data_mem [WAYS][SETS];
   logic [SETS-1:0]  valid_q  [WAYS];
   logic [SETS-1:0]  valid_d  [WAYS];
   logic [SETS-1:0]  dirty_q  [WAYS];
   logic [SETS-1:0]  dirty_d  [WAYS];

   logic [WORD_SIZE-1:0] data_out_q, data_out_d;
   logic [BLK_W-1:0]     dirty_block_q, dirty_block_d;
   logic [TAG_W-1:0]     evict_tag_q, evict_tag_d;
   logic                 done_q, done_d;

   logic [WAYS-1:0]  hit_vec, valid_vec;
   logic [WAY_W-1:0] hit_way, victim, touch_way;
   logic [BLK_W-1:0] hit_blk, victim_blk, wr_blk;
   logic             do_refill, do_write, do_read, miss, touch;

   always_comb begin
      hit_vec   = '0;
      valid_vec = '0;
      hit_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         valid_vec[w] = valid_q[w][index];
         hit_vec[w]   = valid_q[w][index] && (tag_mem[w][index] == tag);
         if (hit_vec[w])
            hit_way = WAY_W'(w);
      end
   end

   assign hit        = |hit_vec;
   assign dirty_bit  = valid_q[victim][index] && dirty_q[victim][index];
   assign hit_blk    = data_mem[hit_way][index];
   assign victim_blk = data_mem[victim][index];

   assign do_refill = ready_mem && write_en_cache;
   assign do_write  = !do_refill && req_type && hit && write_en_cache;
   assign do_read   = !do_refill && !do_write && !req_type && hit && read_en_cache;
   assign miss      = read_en_cache && !hit;
   assign touch     = do_refill || do_write || do_read;
   assign touch_way = do_refill ? victim : hit_way;

   cache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk       (clk),
      .rst       (rst),
      .index     (index),
      .touch     (touch),
      .touch_way (touch_way),
      .valid     (valid_vec),
      .victim    (victim)
   );

   always_comb begin
      wr_blk = hit_blk;
`ifdef CACHE_BYTE_WRITE_EN
      for (int b = 0; b < WORD_SIZE / 8; b++)
         if (byte_en[b])
            wr_blk[int'(blk_offset)*WORD_SIZE + b*8 +: 8] = data_in[b*8 +: 8];
`else
      wr_blk[int'(blk_offset)*WORD_SIZE +: WORD_SIZE] = data_in;
`endif
   end

   always_comb begin
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      data_out_d    = '0;
      done_d        = touch;
      dirty_block_d = dirty_block_q;
      evict_tag_d   = evict_tag_q;
      if (do_refill) begin
         valid_d[victim][index] = 1'b1;
         dirty_d[victim][index] = 1'b0;
      end else if (do_write) begin
         dirty_d[hit_way][index] = 1'b1;
      end else if (do_read) begin
         data_out_d = hit_blk[int'(blk_offset)*WORD_SIZE +: WORD_SIZE];
      end
      // Victim capture reads pre-edge state, so it is independent of a same-cycle refill.
      if (miss) begin
         dirty_block_d = dirty_bit ? victim_blk : '0;
         evict_tag_d   = dirty_bit ? tag_mem[victim][index] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_refill) begin
         data_mem[victim][index] <= data_in_mem;
         tag_mem[victim][index]  <= tag;
      end else if (do_write) begin
         data_mem[hit_way][index] <= wr_blk;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
         data_out_q    <= '0;
         done_q        <= 1'b0;
         dirty_block_q <= '0;
         evict_tag_q   <= '0;
      end else begin
         valid_q       <= valid_d;
         dirty_q       <= dirty_d;
         data_out_q    <= data_out_d;
         done_q        <= done_d;
         dirty_block_q <= dirty_block_d;
         evict_tag_q   <= evict_tag_d;
      end
   end

   assign data_out        = data_out_q;
   assign done_cache      = done_q;
   assign dirty_block_out = dirty_block_q;
   assign evict_tag       = evict_tag_q;

endmodule

// File: tb/tb_set_assoc_cache_memory.sv
// Bench for set_assoc_cache_memory: directed table, reset corner, random ops against a recency-list model.
module tb_set_assoc_cache_memory;

   localparam int WAYS = 2, SETS = 64, WORDS = 4, WS = 32, TW = 24;
   localparam int BW = WORDS * WS;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] tag;
   logic [5:0]    index;
   logic [1:0]    blk_offset;
   logic          req_type, read_en_cache, write_en_cache, ready_mem;
   logic [BW-1:0] data_in_mem;
   logic [WS-1:0] data_in;
`ifdef CACHE_BYTE_WRITE_EN
   logic [3:0]    byte_en;
`endif
   logic          hit, dirty_bit, done_cache;
   logic [WS-1:0] data_out;
   logic [BW-1:0] dirty_block_out;
   logic [TW-1:0] evict_tag;

   always #5 clk = ~clk;

   set_assoc_cache_memory dut (
      .clk             (clk),
      .rst             (rst),
      .tag             (tag),
      .index           (index),
      .blk_offset      (blk_offset),
      .req_type        (req_type),
      .read_en_cache   (read_en_cache),
      .write_en_cache  (write_en_cache),
      .ready_mem       (ready_mem),
      .data_in_mem     (data_in_mem),
      .data_in         (data_in),
`ifdef CACHE_BYTE_WRITE_EN
      .byte_en         (byte_en),
`endif
      .hit             (hit),
      .dirty_bit       (dirty_bit),
      .data_out        (data_out),
      .dirty_block_out (dirty_block_out),
      .evict_tag       (evict_tag),
      .done_cache      (done_cache)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: per-set recency list (position 0 = most recent).
   bit            m_valid [SETS][WAYS];
   bit            m_dirty [SETS][WAYS];
   logic [TW-1:0] m_tag   [SETS][WAYS];
   logic [WS-1:0] m_data  [SETS][WAYS][WORDS];
   int            m_order [SETS][WAYS];
   logic [WS-1:0] e_dout;
   bit            e_done;
   logic [TW-1:0] e_ev;
   logic [BW-1:0] e_dbo;

   function automatic void m_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_order[s][w] = w;
         end
      e_dout = '0; e_done = 0; e_ev = '0; e_dbo = '0;
   endfunction

   function automatic int m_lookup(input int s, input logic [TW-1:0] t);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic int m_victim(input int s);
      for (int w = 0; w < WAYS; w++)
         if (!m_valid[s][w]) return w;
      return m_order[s][WAYS-1];
   endfunction

   function automatic void m_touch(input int s, input int w);
      int p = 0;
      for (int i = 0; i < WAYS; i++)
         if (m_order[s][i] == w) p = i;
      for (int i = p; i > 0; i--)
         m_order[s][i] = m_order[s][i-1];
      m_order[s][0] = w;
   endfunction

   function automatic logic [BW-1:0] m_block(input int s, input int w);
      logic [BW-1:0] b;
      for (int k = 0; k < WORDS; k++) b[k*WS +: WS] = m_data[s][w][k];
      return b;
   endfunction

   task automatic apply(input bit re, input bit we, input bit rm, input bit rt,
                        input logic [TW-1:0] t, input logic [5:0] ix, input logic [1:0] off,
                        input logic [WS-1:0] din, input logic [3:0] be, input logic [BW-1:0] blk,
                        input bit mchk,
                        output bit a_hit, output bit a_db, output logic [WS-1:0] a_dout,
                        output bit a_done);
      int hw, vw;
      bit h, db, refill, wr, rd;
      logic [3:0] be_eff;
      read_en_cache = re; write_en_cache = we; ready_mem = rm; req_type = rt;
      tag = t; index = ix; blk_offset = off; data_in = din; data_in_mem = blk;
`ifdef CACHE_BYTE_WRITE_EN
      byte_en = be;
      be_eff  = be;
`else
      be_eff  = 4'hF;
`endif
      #1;
      hw = m_lookup(ix, t);
      h  = (hw >= 0);
      vw = m_victim(ix);
      db = m_valid[ix][vw] && m_dirty[ix][vw];
      a_hit = hit;
      a_db  = dirty_bit;
      if (mchk) begin
         chk("hit", BW'(hit), BW'(h));
         chk("dirty_bit", BW'(dirty_bit), BW'(db));
      end
      refill = rm && we;
      wr     = !refill && rt && h && we;
      rd     = !refill && !wr && !rt && h && re;
      e_dout = '0;
      if (rd) e_dout = m_data[ix][hw][off];
      e_done = refill || wr || rd;
      if (re && !h) begin
         e_ev  = db ? m_tag[ix][vw] : '0;
         e_dbo = db ? m_block(ix, vw) : '0;
      end
      @(posedge clk);
      if (refill) begin
         m_valid[ix][vw] = 1;
         m_dirty[ix][vw] = 0;
         m_tag[ix][vw]   = t;
         for (int k = 0; k < WORDS; k++) m_data[ix][vw][k] = blk[k*WS +: WS];
         m_touch(ix, vw);
      end else if (wr) begin
         for (int b = 0; b < 4; b++)
            if (be_eff[b]) m_data[ix][hw][off][b*8 +: 8] = din[b*8 +: 8];
         m_dirty[ix][hw] = 1;
         m_touch(ix, hw);
      end else if (rd) begin
         m_touch(ix, hw);
      end
      #1;
      a_dout = data_out;
      a_done = done_cache;
      if (mchk) begin
         chk("data_out", BW'(data_out), BW'(e_dout));
         chk("done_cache", BW'(done_cache), BW'(e_done));
         chk("evict_tag", BW'(evict_tag), BW'(e_ev));
         chk("dirty_block_out", dirty_block_out, e_dbo);
      end
   endtask

   typedef struct {
      bit            re, we, rm, rt;
      logic [TW-1:0] t;
      logic [1:0]    off;
      logic [WS-1:0] din;
      logic [BW-1:0] blk;
      bit            x_hit, x_db;
      logic [WS-1:0] x_dout;
      bit            x_done;
      logic [TW-1:0] x_ev;
      logic [BW-1:0] x_dbo;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t          tbl [17];
      logic [TW-1:0] tT, tA, tB, tC;
      logic [BW-1:0] b1, bA, bB, bD, bEv;
      bit            ah, adb, adn;
      logic [WS-1:0] ado;

      tT = 24'h000123; tA = 24'h0000A1; tB = 24'h0000B2; tC = 24'h0000C3;
      b1  = {32'h44, 32'h33, 32'h22, 32'h11};
      bA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      bB  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      bD  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      bEv = {32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0};

      tbl[0]  = '{1,0,0,0, tT, 0, 0, '0,            0,0, 0,        0, 0,  '0};
      tbl[1]  = '{0,1,1,0, tT, 0, 0, b1,            0,0, 0,        1, 0,  '0};
      tbl[2]  = '{1,0,0,0, tT, 2, 0, '0,            1,0, 32'h33,   1, 0,  '0};
      tbl[3]  = '{0,0,0,0, tT, 0, 0, '0,            1,0, 0,        0, 0,  '0};
      tbl[4]  = '{1,0,0,0, tA, 0, 0, '0,            0,0, 0,        0, 0,  '0};
      tbl[5]  = '{0,1,1,0, tA, 0, 0, bA,            0,0, 0,        1, 0,  '0};
      tbl[6]  = '{0,1,1,0, tB, 0, 0, bB,            0,0, 0,        1, 0,  '0};
      tbl[7]  = '{1,0,0,0, tA, 0, 0, '0,            1,0, 32'hA0,   1, 0,  '0};
      tbl[8]  = '{1,0,0,0, tC, 0, 0, '0,            0,0, 0,        0, 0,  '0};
      tbl[9]  = '{1,0,0,0, tA, 3, 0, '0,            1,0, 32'hA3,   1, 0,  '0};
      tbl[10] = '{0,1,0,1, tA, 1, 32'hDEADBEEF, '0, 1,0, 0,        1, 0,  '0};
      tbl[11] = '{1,0,0,0, tB, 0, 0, '0,            1,0, 32'hB0,   1, 0,  '0};
      tbl[12] = '{1,0,0,0, tC, 0, 0, '0,            0,1, 0,        0, tA, bEv};
      tbl[13] = '{0,1,1,1, tA, 1, 32'h12345678, bD, 1,1, 0,        1, tA, bEv};
      tbl[14] = '{1,0,0,0, tA, 1, 0, '0,            1,0, 32'hD1,   1, tA, bEv};
      tbl[15] = '{1,0,0,0, tB, 2, 0, '0,            1,0, 32'hB2,   1, tA, bEv};
      tbl[16] = '{1,0,0,0, tC, 0, 0, '0,            0,0, 0,        0, 0,  '0};

      rst = 1'b1;
      read_en_cache = 0; write_en_cache = 0; ready_mem = 0; req_type = 0;
      tag = '0; index = '0; blk_offset = '0; data_in = '0; data_in_mem = '0;
`ifdef CACHE_BYTE_WRITE_EN
      byte_en = '0;
`endif
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset data_out", BW'(data_out), '0);
      chk("reset done_cache", BW'(done_cache), '0);
      chk("reset evict_tag", BW'(evict_tag), '0);
      chk("reset dirty_block_out", dirty_block_out, '0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].re, tbl[i].we, tbl[i].rm, tbl[i].rt, tbl[i].t, 6'd5, tbl[i].off,
               tbl[i].din, 4'hF, tbl[i].blk, 1'b0, ah, adb, ado, adn);
         chk($sformatf("vec%0d hit", i), BW'(ah), BW'(tbl[i].x_hit));
         chk($sformatf("vec%0d dirty_bit", i), BW'(adb), BW'(tbl[i].x_db));
         chk($sformatf("vec%0d data_out", i), BW'(ado), BW'(tbl[i].x_dout));
         chk($sformatf("vec%0d done_cache", i), BW'(adn), BW'(tbl[i].x_done));
         chk($sformatf("vec%0d evict_tag", i), BW'(evict_tag), BW'(tbl[i].x_ev));
         chk($sformatf("vec%0d dirty_block_out", i), dirty_block_out, tbl[i].x_dbo);
      end

      // Reset asserted while a refill is presented: refill is dropped, lookups miss.
      read_en_cache = 0; write_en_cache = 1; ready_mem = 1; req_type = 0;
      tag = 24'h0000E7; index = 6'd9; data_in_mem = bB;
      #2 rst = 1'b1;
      #1;
      chk("async reset done_cache", BW'(done_cache), '0);
      chk("async reset data_out", BW'(data_out), '0);
      @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      apply(1, 0, 0, 0, 24'h0000E7, 6'd9, 0, 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
      apply(1, 0, 0, 0, tA, 6'd5, 0, 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
      chk("post-reset lookup A", BW'(ah), '0);

      for (int n = 0; n < 600; n++) begin
         logic [TW-1:0] rt_tag;
         logic [5:0]    rix;
         int            op;
         rt_tag = TW'($urandom_range(0, 3)) + 24'h000100;
         rix    = ($urandom_range(0, 1) != 0) ? 6'd3 : 6'd17;
         op     = $urandom_range(0, 4);
         case (op)
            0: apply(1, 0, 0, 0, rt_tag, rix, 2'($urandom), 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
            1: apply($urandom_range(0, 1) != 0, 1, 0, 1, rt_tag, rix, 2'($urandom), $urandom,
                     4'($urandom), '0, 1'b1, ah, adb, ado, adn);
            2: if (m_lookup(rix, rt_tag) < 0)
                  apply(0, 1, 1, $urandom_range(0, 1) != 0, rt_tag, rix, 0, $urandom, 4'hF,
                        {$urandom, $urandom, $urandom, $urandom}, 1'b1, ah, adb, ado, adn);
               else
                  apply(1, 0, 0, 0, rt_tag, rix, 2'($urandom), 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
            3: apply(0, 0, $urandom_range(0, 1) != 0, 0, rt_tag, rix, 0, 0, 4'hF, '0, 1'b1,
                     ah, adb, ado, adn);
            default: apply(1, 1, 0, $urandom_range(0, 1) != 0, rt_tag, rix, 2'($urandom),
                           $urandom, 4'($urandom), '0, 1'b1, ah, adb, ado, adn);
         endcase
      end

`ifdef CACHE_BYTE_WRITE_EN
      apply(1, 0, 0, 0, 24'h0000F0, 6'd40, 0, 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
      apply(0, 1, 1, 0, 24'h0000F0, 6'd40, 0, 0, 4'hF, {96'h0, 32'h11223344}, 1'b1, ah, adb, ado, adn);
      apply(0, 1, 0, 1, 24'h0000F0, 6'd40, 0, 32'hAABBCCDD, 4'b0011, '0, 1'b1, ah, adb, ado, adn);
      apply(1, 0, 0, 0, 24'h0000F0, 6'd40, 0, 0, 4'hF, '0, 1'b1, ah, adb, ado, adn);
      chk("byte write merge", BW'(ado), BW'(32'h1122CCDD));
      apply(0, 1, 0, 1, 24'h0000F0, 6'd40, 0, 32'h55555555, 4'b0000, '0, 1'b1, ah, adb, ado, adn);
      chk("byte_en zero done", BW'(adn), BW'(1'b1));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
